// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the multiplexed 16-bit AddrData bus of the memory controller between
// NREQ requesters. A granted requester gets one address cycle followed by
// BURST data beats. Requesters are served round-robin, and bursts may run
// back-to-back with no idle cycle between them.
//
// Ports
//   clk, reset   clock and asynchronous active-high reset
//   req          per-requester request level, sampled only at arbitration
//   req_rw       1 = read, 0 = write, sampled together with req at grant
//   req_addr     NREQ x AW start addresses, sampled at grant
//   req_wdata    NREQ x 16 write words; the granted word is put on the bus
//   gnt          one-hot grant, from the address cycle through the last beat
//   beat_ack     one-cycle strobe per data beat
//   rvalid       read beat valid; rdata carries the bus value
//   rdata        read word (low 16 bits of AddrData)
//   done         one-cycle pulse on the last beat
//   AddrData     bus to the memory controller (tristated on read beats)
//   AddrValid    high only in the address cycle
//   rw           transfer direction, held for the whole burst
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NREQ  = 2,
  parameter int BURST = 4,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_rw,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*16-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    beat_ack,
  output logic [NREQ-1:0]    rvalid,
  output logic [15:0]        rdata,
  output logic [NREQ-1:0]    done,
  inout  wire  [15:0]        AddrData,
  output logic               AddrValid,
  output logic               rw
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Round-robin search: first requester with req high, starting at 'start'.
  // Returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [IW-1:0]   start);
    logic          found;
    logic [IW-1:0] win;
    int            j;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(start) + i) % NREQ;
      if (!found && r[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            tx_rw_q, tx_rw_d;
  logic [AW-1:0]   tx_addr_q, tx_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Registered bus-side outputs, decoded from the next state.
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] beat_ack_q, beat_ack_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            addr_valid_q, addr_valid_d;
  logic            rw_q, rw_d;
  logic            drive_addr_q, drive_addr_d;
  logic            drive_wr_q, drive_wr_d;

  logic            last_beat_s;
  logic [IW-1:0]   nxt_ptr_s;
  logic [IW-1:0]   arb_ptr_s;
  logic [IW:0]     pick_s;
  logic [IW-1:0]   pick_idx_s;
  logic [15:0]     addr_ext_s;
  logic [15:0]     wdata_sel_s;

  assign last_beat_s = (cnt_q == CW'(BURST - 1));
  assign nxt_ptr_s   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
  // On the last beat the search already starts after the current owner.
  assign arb_ptr_s   = (state_q == S_DATA && last_beat_s) ? nxt_ptr_s : ptr_q;
  assign pick_s      = rr_pick(req, arb_ptr_s);
  assign pick_idx_s  = pick_s[IW-1:0];

  // Next-state, latch and output decode for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    tx_rw_d   = tx_rw_q;
    tx_addr_d = tx_addr_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick_s[IW]) begin
          state_d   = S_ADDR;
          idx_d     = pick_idx_s;
          tx_rw_d   = req_rw[pick_idx_s];
          tx_addr_d = req_addr[int'(pick_idx_s)*AW +: AW];
          cnt_d     = '0;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (last_beat_s) begin
          ptr_d = nxt_ptr_s;
          if (pick_s[IW]) begin
            state_d   = S_ADDR;
            idx_d     = pick_idx_s;
            tx_rw_d   = req_rw[pick_idx_s];
            tx_addr_d = req_addr[int'(pick_idx_s)*AW +: AW];
            cnt_d     = '0;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    gnt_d        = '0;
    beat_ack_d   = '0;
    rvalid_d     = '0;
    done_d       = '0;
    addr_valid_d = 1'b0;
    rw_d         = 1'b0;
    drive_addr_d = 1'b0;
    drive_wr_d   = 1'b0;
    case (state_d)
      S_ADDR: begin
        gnt_d        = one_hot(idx_d);
        addr_valid_d = 1'b1;
        rw_d         = tx_rw_d;
        drive_addr_d = 1'b1;
      end
      S_DATA: begin
        gnt_d      = one_hot(idx_d);
        beat_ack_d = one_hot(idx_d);
        rw_d       = tx_rw_d;
        rvalid_d   = tx_rw_d ? one_hot(idx_d) : '0;
        done_d     = (cnt_d == CW'(BURST - 1)) ? one_hot(idx_d) : '0;
        drive_wr_d = ~tx_rw_d;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      tx_rw_q      <= 1'b0;
      tx_addr_q    <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      beat_ack_q   <= '0;
      rvalid_q     <= '0;
      done_q       <= '0;
      addr_valid_q <= 1'b0;
      rw_q         <= 1'b0;
      drive_addr_q <= 1'b0;
      drive_wr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      tx_rw_q      <= tx_rw_d;
      tx_addr_q    <= tx_addr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      beat_ack_q   <= beat_ack_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      addr_valid_q <= addr_valid_d;
      rw_q         <= rw_d;
      drive_addr_q <= drive_addr_d;
      drive_wr_q   <= drive_wr_d;
    end
  end

  assign addr_ext_s  = 16'(tx_addr_q);
  assign wdata_sel_s = req_wdata[int'(idx_q)*16 +: 16];

  // Write data goes straight from the granted requester to the bus so that
  // beat_ack and the consumed word line up in the same cycle.
  assign AddrData = drive_addr_q ? addr_ext_s :
                    (drive_wr_q ? wdata_sel_s : 16'hzzzz);

  assign rdata     = (|rvalid_q) ? AddrData : 16'h0000;
  assign gnt       = gnt_q;
  assign beat_ack  = beat_ack_q;
  assign rvalid    = rvalid_q;
  assign done      = done_q;
  assign AddrValid = addr_valid_q;
  assign rw        = rw_q;

endmodule
